// File: rtl/uart_tx_fifo_if.sv
// Producer-side byte handshake for the UART transmitter.
// The producer (master) offers a byte with tx_valid.
// The transmitter (slave) takes it on any edge where tx_valid && tx_ready.
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small input FIFO.
// Bytes queue in the FIFO and are shifted out LSB first on a registered TXD.
// When more bytes are waiting, frames follow each other back to back with no idle gap.
module uart_tx_fifo #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DEPTH       = 4
) (
    input  logic                         CLK,
    input  logic                         RESET,
    uart_tx_fifo_if.slave                s,
    output logic                         TXD,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int CPB   = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CPB - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

    generate
        if (CPB < 2) begin : g_bad_baud
            $error("uart_tx_fifo: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             txd_q;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;

    logic             fifo_empty;
    logic             baud_last;
    logic             push;
    logic             pop;

    assign fifo_empty = (level == '0);
    assign baud_last  = (baud_cnt == BAUD_LAST);

    // Ready depends only on registered occupancy, never on tx_valid, so there is no comb loop.
    assign s.tx_ready = !RESET && (level != LVL_FULL);
    assign push       = s.tx_valid && s.tx_ready;

    // Pop when the line is free: either idle, or on the final cycle of a stop bit.
    assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_last));

    assign TXD        = txd_q;
    assign fifo_level = level;
    assign busy       = (state != IDLE) || !fifo_empty;

    // FIFO storage: data only, written on an accepted handshake.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= s.tx_data;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Frame sequencer: start bit, eight data bits LSB first, stop bit, each CPB cycles long.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            txd_q    <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    txd_q    <= 1'b1;
                    baud_cnt <= '0;
                    if (!fifo_empty) begin
                        shift <= mem[rd_ptr];
                        txd_q <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        txd_q    <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd_q <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            txd_q   <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (!fifo_empty) begin
                            shift <= mem[rd_ptr];
                            txd_q <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    txd_q <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
